// File: rtl/char_console_writer.sv
// Terminal-style writer for the screen character RAM: prints an ASCII byte stream at a
// cursor, handles CR/LF, wraps lines/screen and blanks lines. Optional: CONSOLE_BACKSPACE_EN.
module char_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 25
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clear_req,
  output logic [10:0] write_character_pos,
  output logic [7:0]  write_character,
  output logic        write_strobe,
  output logic [10:0] cursor_pos,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam int ADDR_W = 11;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_ALL  = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(COLS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [7:0]        SPACE     = 8'h20;
  localparam logic [7:0]        LF        = 8'h0A;
  localparam logic [7:0]        CR        = 8'h0D;
`ifdef CONSOLE_BACKSPACE_EN
  localparam logic [7:0]        BS        = 8'h08;
`endif

  // Handshake: a byte transfers on a rising CLK edge where in_valid && in_ready;
  // in_ready is only high in IDLE with no clear request pending in that cycle.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR_LINE = 2'd1,
    CLEAR_ALL  = 2'd2
  } state_e;

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   count, count_nxt;
  logic [ROW_W-1:0]    row, row_nxt;
  logic [COL_W-1:0]    col, col_nxt;
  logic                clear_pend, pend_nxt;
  logic                strobe_nxt;
  logic [ADDR_W-1:0]   wpos_nxt, cursor_nxt;
  logic [7:0]          wchar_nxt;

  logic [ROW_W-1:0]    next_row;
  logic [ADDR_W-1:0]   row_base, next_base, cur_addr;

  assign next_row  = (row == LAST_ROW) ? '0 : row + ROW_W'(1);
  assign row_base  = ADDR_W'(row) * COLS_A;
  assign next_base = ADDR_W'(next_row) * COLS_A;
  assign cur_addr  = row_base + ADDR_W'(col);

  assign in_ready  = (state == IDLE) && !clear_req;
  assign state_dbg = state;

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    row_nxt    = row;
    col_nxt    = col;
    pend_nxt   = clear_pend;
    strobe_nxt = 1'b0;
    wpos_nxt   = write_character_pos;
    wchar_nxt  = write_character;
    cursor_nxt = cursor_pos;

    case (state)
      CLEAR_ALL: begin
        strobe_nxt = 1'b1;
        wpos_nxt   = count;
        wchar_nxt  = SPACE;
        if (count == LAST_ALL) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else begin
          count_nxt = count + ADDR_W'(1);
        end
      end

      CLEAR_LINE: begin
        strobe_nxt = 1'b1;
        wpos_nxt   = row_base + count;
        wchar_nxt  = SPACE;
        cursor_nxt = row_base;
        if (clear_req) pend_nxt = 1'b1;
        if (count == LAST_LINE) begin
          count_nxt = '0;
          // A clear request seen during the line (including its last cycle) chains into a full clear.
          if (clear_pend || clear_req) begin
            state_nxt  = CLEAR_ALL;
            pend_nxt   = 1'b0;
            row_nxt    = '0;
            col_nxt    = '0;
            cursor_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          count_nxt = count + ADDR_W'(1);
        end
      end

      IDLE: begin
        if (clear_req) begin
          state_nxt  = CLEAR_ALL;
          count_nxt  = '0;
          row_nxt    = '0;
          col_nxt    = '0;
          cursor_nxt = '0;
        end else if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            strobe_nxt = 1'b1;
            wpos_nxt   = cur_addr;
            wchar_nxt  = in_data;
            if (col == LAST_COL) begin
              col_nxt    = '0;
              row_nxt    = next_row;
              state_nxt  = CLEAR_LINE;
              count_nxt  = '0;
              cursor_nxt = next_base;
            end else begin
              col_nxt    = col + COL_W'(1);
              cursor_nxt = cur_addr + ADDR_W'(1);
            end
          end else if (in_data == LF) begin
            col_nxt    = '0;
            row_nxt    = next_row;
            state_nxt  = CLEAR_LINE;
            count_nxt  = '0;
            cursor_nxt = next_base;
          end else if (in_data == CR) begin
            col_nxt    = '0;
            cursor_nxt = row_base;
          end
`ifdef CONSOLE_BACKSPACE_EN
          else if (in_data == BS && col != '0) begin
            col_nxt    = col - COL_W'(1);
            strobe_nxt = 1'b1;
            wpos_nxt   = cur_addr - ADDR_W'(1);
            wchar_nxt  = SPACE;
            cursor_nxt = cur_addr - ADDR_W'(1);
          end
`endif
        end
      end

      default: begin
        state_nxt = CLEAR_ALL;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state               <= CLEAR_ALL;
      count               <= '0;
      row                 <= '0;
      col                 <= '0;
      clear_pend          <= 1'b0;
      write_strobe        <= 1'b0;
      write_character_pos <= '0;
      write_character     <= SPACE;
      cursor_pos          <= '0;
      busy                <= 1'b1;
    end else begin
      state               <= state_nxt;
      count               <= count_nxt;
      row                 <= row_nxt;
      col                 <= col_nxt;
      clear_pend          <= pend_nxt;
      write_strobe        <= strobe_nxt;
      write_character_pos <= wpos_nxt;
      write_character     <= wchar_nxt;
      cursor_pos          <= cursor_nxt;
      busy                <= (state_nxt != IDLE);
    end
  end

endmodule
